// File: rtl/zx_pixel_serializer.sv
// rtl/zx_pixel_serializer.sv - ZX video pixel serializer with attribute decode, flash and border port
module zx_pixel_serializer #(
    parameter int DW           = 8,
    parameter int FLASH_FRAMES = 16,
    parameter int BORDER_W     = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                PIX_CE,
    input  logic [DW-1:0]       Q,
    input  logic                LD_PIX,
    input  logic                LD_ATTR,
    input  logic                LOAD,
    input  logic                BL,
    input  logic                BORDER_EN,
    input  logic                FRAME,
    input  logic [3:0]          D,
    input  logic                WR_N,
    input  logic                IORQ_N,
    input  logic                A0,
    output logic                R,
    output logic                G,
    output logic                B,
    output logic                I,
    output logic                FLASH,
    output logic [BORDER_W-1:0] BORDER
);

    localparam int CW = $clog2(FLASH_FRAMES);

    logic [DW-1:0] pix_l;
    logic [7:0]    attr_l;
    logic [DW-1:0] shift_q;
    logic [7:0]    attr_s;
    logic [CW-1:0] flash_cnt;

    logic          port_sel;
    logic          sel_m;
    logic          sel_s;
    logic          sel_d;
    logic [3:0]    d_m;
    logic [3:0]    d_s;
    logic [3:0]    d_hold;

    logic          pix_bit;
    logic [2:0]    field;
    logic [3:0]    border_x;
    logic [3:0]    rgbi_next;
    logic          border_unused;

    // Only the low BORDER_W bits of the held CPU nibble reach the border register.
    assign border_unused = ^d_hold;

    // Byte latches filled from the video bus ahead of the next LOAD.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pix_l  <= '0;
            attr_l <= '0;
        end else if (PIX_CE) begin
            if (LD_PIX)  pix_l  <= Q;
            if (LD_ATTR) attr_l <= Q[7:0];
        end
    end

    // Shift stage: LOAD takes the pre-edge latch contents, otherwise shift MSB-first.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            shift_q <= '0;
            attr_s  <= '0;
        end else if (PIX_CE) begin
            if (LOAD) begin
                shift_q <= pix_l;
                attr_s  <= attr_l;
            end else begin
                shift_q <= {shift_q[DW-2:0], 1'b0};
            end
        end
    end

    // Flash phase: counts frame pulses, toggles FLASH on each wrap.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            flash_cnt <= '0;
            FLASH     <= 1'b0;
        end else if (FRAME) begin
            if (flash_cnt == CW'(FLASH_FRAMES - 1)) begin
                flash_cnt <= '0;
                FLASH     <= ~FLASH;
            end else begin
                flash_cnt <= flash_cnt + CW'(1);
            end
        end
    end

    assign port_sel = ~WR_N & ~IORQ_N & ~A0;

    // Bring the asynchronous CPU strobe and data into the clock domain together.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sel_m <= 1'b0;
            sel_s <= 1'b0;
            sel_d <= 1'b0;
            d_m   <= '0;
            d_s   <= '0;
        end else begin
            sel_m <= port_sel;
            sel_s <= sel_m;
            sel_d <= sel_s;
            d_m   <= D;
            d_s   <= d_m;
        end
    end

    // Track data during the strobe; commit the last value when the strobe ends.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            d_hold <= '0;
            BORDER <= '0;
        end else begin
            if (sel_s) d_hold <= d_s;
            if (sel_d && !sel_s) BORDER <= d_hold[BORDER_W-1:0];
        end
    end

    assign border_x = 4'(BORDER);

    // Pixel decode and colour priority mux: blanking, then border, then ink/paper.
    always_comb begin
        pix_bit   = shift_q[DW-1] ^ (attr_s[7] & FLASH);
        field     = pix_bit ? attr_s[2:0] : attr_s[5:3];
        rgbi_next = {field[1], field[2], field[0], attr_s[6]};
        if (BL) begin
            rgbi_next = 4'b0000;
        end else if (BORDER_EN) begin
            rgbi_next = {border_x[1], border_x[2], border_x[0], border_x[3]};
        end
    end

    // Registered colour outputs, updated once per pixel.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            {R, G, B, I} <= 4'b0000;
        end else if (PIX_CE) begin
            {R, G, B, I} <= rgbi_next;
        end
    end

endmodule

// File: tb/tb_zx_pixel_serializer.sv
// tb/tb_zx_pixel_serializer.sv - self-checking bench for zx_pixel_serializer
module tb_zx_pixel_serializer;

    localparam int DW = 8;
    localparam int FF = 16;
    localparam int BW = 3;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          PIX_CE = 1'b0;
    logic [DW-1:0] Q = '0;
    logic          LD_PIX = 1'b0;
    logic          LD_ATTR = 1'b0;
    logic          LOAD = 1'b0;
    logic          BL = 1'b0;
    logic          BORDER_EN = 1'b0;
    logic          FRAME = 1'b0;
    logic [3:0]    D = '0;
    logic          WR_N = 1'b1;
    logic          IORQ_N = 1'b1;
    logic          A0 = 1'b1;
    logic          R, G, B, I, FLASH;
    logic [BW-1:0] BORDER;

    zx_pixel_serializer #(.DW(DW), .FLASH_FRAMES(FF), .BORDER_W(BW)) dut (
        .CLK(CLK), .RESET(RESET), .PIX_CE(PIX_CE), .Q(Q), .LD_PIX(LD_PIX),
        .LD_ATTR(LD_ATTR), .LOAD(LOAD), .BL(BL), .BORDER_EN(BORDER_EN),
        .FRAME(FRAME), .D(D), .WR_N(WR_N), .IORQ_N(IORQ_N), .A0(A0),
        .R(R), .G(G), .B(B), .I(I), .FLASH(FLASH), .BORDER(BORDER)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state: words by pixel index rather than a shift register.
    logic [DW-1:0] m_pix_l = '0, m_word = '0;
    logic [7:0]    m_attr_l = '0, m_attr = '0;
    int            m_k = 0;
    int            m_frames = 0;
    logic [3:0]    m_rgbi = '0;
    logic [3:0]    m_border = '0, m_last_d = '0;
    bit            m_sel_prev = 1'b0, m_pend = 1'b0, sel_now;
    int            m_cnt = 0;
    logic          m_p;
    logic [2:0]    m_field;

    function automatic logic m_flash();
        return ((m_frames / FF) % 2) != 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    // Model: advances on every clock edge, cleared by reset.
    initial forever begin
        @(posedge CLK or negedge RESET);
        if (!RESET) begin
            m_pix_l = '0; m_word = '0; m_attr_l = '0; m_attr = '0; m_k = 0;
            m_frames = 0; m_rgbi = '0; m_border = '0; m_last_d = '0;
            m_sel_prev = 1'b0; m_pend = 1'b0; m_cnt = 0;
        end else begin
            sel_now = !WR_N && !IORQ_N && !A0;
            if (PIX_CE) begin
                m_p = ((m_k < DW) ? m_word[DW-1-m_k] : 1'b0) ^ (m_attr[7] & m_flash());
                m_field = m_p ? m_attr[2:0] : m_attr[5:3];
                if (BL)
                    m_rgbi = 4'b0000;
                else if (BORDER_EN)
                    m_rgbi = {m_border[1], m_border[2], m_border[0], (BW == 4) ? m_border[3] : 1'b0};
                else
                    m_rgbi = {m_field[1], m_field[2], m_field[0], m_attr[6]};
                if (LOAD) begin
                    m_word = m_pix_l; m_attr = m_attr_l; m_k = 0;
                end else if (m_k < DW) begin
                    m_k++;
                end
                if (LD_PIX)  m_pix_l  = Q;
                if (LD_ATTR) m_attr_l = Q[7:0];
            end
            if (FRAME) m_frames++;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_border = m_last_d & 4'((1 << BW) - 1);
                    m_pend = 1'b0;
                end
            end
            if (m_sel_prev && !sel_now) begin
                m_pend = 1'b1;
                m_cnt = 2;
            end
            if (sel_now) m_last_d = D;
            m_sel_prev = sel_now;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            check("cyc_rgbi", {R, G, B, I}, m_rgbi);
            check("cyc_flash", FLASH, m_flash());
            check("cyc_border", BORDER, m_border[BW-1:0]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [3:0] seq1 [9] = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'hF, 4'h1, 4'hF, 4'h1};
    logic [3:0] seq2 [4] = '{4'h0, 4'h0, 4'hE, 4'hE};

    task automatic port_write(input logic [3:0] val);
        D = val; WR_N = 1'b0; IORQ_N = 1'b0; A0 = 1'b0;
        repeat (4) cyc();
        WR_N = 1'b1; IORQ_N = 1'b1; A0 = 1'b1; D = 4'h0;
    endtask

    initial begin
        #1 RESET = 1'b0;
        repeat (2) cyc();
        check("rst_rgbi", {R, G, B, I}, 4'h0);
        check("rst_flash", FLASH, 1'b0);
        check("rst_border", BORDER, 3'd0);
        RESET = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Pixel 0xA5 with attribute 0x47 (bright white ink on black paper).
        PIX_CE = 1'b1; LD_PIX = 1'b1; Q = 8'hA5; cyc();
        LD_PIX = 1'b0; LD_ATTR = 1'b1; Q = 8'h47; cyc();
        LD_ATTR = 1'b0; LOAD = 1'b1; cyc();
        LOAD = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check("pix_seq", {R, G, B, I}, seq1[i]);
        end

        // Flash: attr 0x87, pixels all ink.
        LD_PIX = 1'b1; Q = 8'hFF; cyc();
        LD_PIX = 1'b0; LD_ATTR = 1'b1; Q = 8'h87; cyc();
        LD_ATTR = 1'b0; LOAD = 1'b1; cyc();
        LOAD = 1'b0; cyc();
        check("flash_ink", {R, G, B, I}, 4'hE);
        PIX_CE = 1'b0;
        for (int i = 0; i < 15; i++) begin
            FRAME = 1'b1; cyc(); FRAME = 1'b0; cyc();
        end
        check("flash_15", FLASH, 1'b0);
        FRAME = 1'b1; cyc(); FRAME = 1'b0;
        check("flash_16", FLASH, 1'b1);
        PIX_CE = 1'b1; cyc(); PIX_CE = 1'b0;
        check("flash_inv", {R, G, B, I}, 4'h0);
        for (int i = 0; i < 16; i++) begin
            FRAME = 1'b1; cyc(); FRAME = 1'b0; cyc();
        end
        check("flash_32", FLASH, 1'b0);
        PIX_CE = 1'b1; cyc();
        check("flash_restore", {R, G, B, I}, 4'hE);

        // Border write through the I/O port.
        BORDER_EN = 1'b1;
        port_write(4'h2);
        cyc(); cyc();
        check("border_t2", BORDER, 3'd0);
        cyc();
        check("border_t3", BORDER, 3'd2);
        cyc();
        check("border_rgbi", {R, G, B, I}, 4'b1000);
        port_write(4'hF);
        repeat (4) cyc();
        check("border_w3", BORDER, 3'd7);
        check("border_w3_i", {R, G, B, I}, 4'b1110);

        // Blanking over active pixels.
        BORDER_EN = 1'b0;
        LD_PIX = 1'b1; Q = 8'hF0; cyc();
        LD_PIX = 1'b0; LD_ATTR = 1'b1; Q = 8'h7F; cyc();
        LD_ATTR = 1'b0; LOAD = 1'b1; BL = 1'b1; cyc();
        LOAD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("bl_black", {R, G, B, I}, 4'h0);
        end
        BL = 1'b0; cyc();
        check("bl_release", {R, G, B, I}, 4'hF);

        // LOAD together with LD_PIX transfers the old latch.
        LD_ATTR = 1'b1; Q = 8'h07; cyc();
        LD_ATTR = 1'b0; LD_PIX = 1'b1; Q = 8'h3C; cyc();
        LOAD = 1'b1; Q = 8'hC3; cyc();
        LD_PIX = 1'b0; LOAD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("ld_old", {R, G, B, I}, seq2[i]);
        end
        LOAD = 1'b1; cyc(); LOAD = 1'b0; cyc();
        check("ld_new", {R, G, B, I}, 4'hE);

        // Reset mid-shift and mid-write.
        D = 4'h5; WR_N = 1'b0; IORQ_N = 1'b0; A0 = 1'b0;
        repeat (3) cyc();
        #1 RESET = 1'b0;
        #1;
        check("rst_mid_rgbi", {R, G, B, I}, 4'h0);
        check("rst_mid_border", BORDER, 3'd0);
        check("rst_mid_flash", FLASH, 1'b0);
        cyc();
        WR_N = 1'b1; IORQ_N = 1'b1; A0 = 1'b1; D = 4'h0;
        cyc();
        RESET = 1'b1;
        repeat (6) cyc();
        check("rst_noupd", BORDER, 3'd0);
        check("rst_after_rgbi", {R, G, B, I}, 4'h0);

        PIX_CE = 1'b0;
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
